// File: rtl/highscore_table_ctrl.sv
// Five-entry sorted high-score table with a sequential compare/shift/write insertion engine.
// Latency: done high 7 edges after start for a placed score, 5 edges for an unplaced one.
// Backpressure: busy stays high until done; start while busy is dropped, clear aborts any state.
module highscore_table_ctrl #(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    input  logic               clear,
    output logic               busy,
    output logic               done,
    output logic [2:0]         rank,
    output logic [SCORE_W-1:0] hi1,
    output logic [SCORE_W-1:0] hi2,
    output logic [SCORE_W-1:0] hi3,
    output logic [SCORE_W-1:0] hi4,
    output logic [SCORE_W-1:0] hi5
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_SHIFT,
        S_WRITE,
        S_DONE
    } state_t;

    // Per-insertion working context.
    typedef struct packed {
        logic [SCORE_W-1:0] cand;
        logic [2:0]         idx;
        logic [2:0]         ptr;
        logic [2:0]         r;
        logic               r_none;
    } ctx_t;

    state_t             state, state_nxt;
    ctx_t               ctx, ctx_nxt;
    logic [2:0]         rank_q, rank_nxt;
    logic [SCORE_W-1:0] hs     [5];
    logic [SCORE_W-1:0] hs_nxt [5];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctx    <= '0;
            rank_q <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                hs[i] <= '0;
            end
        end else begin
            ctx    <= ctx_nxt;
            rank_q <= rank_nxt;
            for (int i = 0; i < 5; i++) begin
                hs[i] <= hs_nxt[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ctx_nxt   = ctx;
        rank_nxt  = rank_q;
        for (int i = 0; i < 5; i++) begin
            hs_nxt[i] = hs[i];
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    ctx_nxt.cand = score;
                    ctx_nxt.idx  = 3'd0;
                    state_nxt    = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // Strict compare: a tie falls through, so the newcomer lands below the incumbent.
                if (ctx.cand > hs[ctx.idx]) begin
                    ctx_nxt.r      = ctx.idx;
                    ctx_nxt.r_none = 1'b0;
                    ctx_nxt.ptr    = 3'd4;
                    state_nxt      = S_SHIFT;
                end else if (ctx.idx == 3'd4) begin
                    ctx_nxt.r_none = 1'b1;
                    rank_nxt       = 3'd0;
                    state_nxt      = S_DONE;
                end else begin
                    ctx_nxt.idx = ctx.idx + 3'd1;
                end
            end
            S_SHIFT: begin
                // Walks from the bottom up so hs[4] is overwritten first and simply drops out.
                if (ctx.ptr == ctx.r) begin
                    state_nxt = S_WRITE;
                end else begin
                    hs_nxt[ctx.ptr] = hs[ctx.ptr - 3'd1];
                    ctx_nxt.ptr     = ctx.ptr - 3'd1;
                end
            end
            S_WRITE: begin
                hs_nxt[ctx.r] = ctx.cand;
                rank_nxt      = ctx.r + 3'd1;
                state_nxt     = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (clear) begin
            state_nxt = S_IDLE;
            rank_nxt  = 3'd0;
            for (int i = 0; i < 5; i++) begin
                hs_nxt[i] = '0;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign rank = rank_q;
    assign hi1  = hs[0];
    assign hi2  = hs[1];
    assign hi3  = hs[2];
    assign hi4  = hs[3];
    assign hi5  = hs[4];

endmodule

// File: tb/tb_highscore_table_ctrl.sv
// Bench for highscore_table_ctrl: sorted-list reference model checked every cycle, plus directed literal cases.
module tb_highscore_table_ctrl;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] score;
    logic       clear;
    logic       busy;
    logic       done;
    logic [2:0] rank;
    logic [7:0] hi1, hi2, hi3, hi4, hi5;

    int errors = 0;
    int checks = 0;

    highscore_table_ctrl #(.SCORE_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .score  (score),
        .clear  (clear),
        .busy   (busy),
        .done   (done),
        .rank   (rank),
        .hi1    (hi1),
        .hi2    (hi2),
        .hi3    (hi3),
        .hi4    (hi4),
        .hi5    (hi5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain sorted list plus "edges since accepted start".
    logic [7:0] m_tbl [5];
    logic [7:0] m_new [5];
    int         m_prank;
    int         m_rank;
    int         m_lat;
    int         m_t;
    bit         m_act;

    task automatic model_insert(input logic [7:0] s);
        int  pos;
        pos = -1;
        for (int i = 0; i < 5; i++) begin
            if (pos < 0 && s > m_tbl[i]) pos = i;
        end
        m_new = m_tbl;
        if (pos < 0) begin
            m_prank = 0;
            m_lat   = 5;
        end else begin
            for (int i = 4; i > pos; i--) m_new[i] = m_tbl[i-1];
            m_new[pos] = s;
            m_prank    = pos + 1;
            m_lat      = 7;
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_act  = 1'b0;
            m_t    = 0;
            m_rank = 0;
            m_lat  = 0;
            for (int i = 0; i < 5; i++) m_tbl[i] = 8'd0;
        end else if (clear) begin
            m_act  = 1'b0;
            m_t    = 0;
            m_rank = 0;
            for (int i = 0; i < 5; i++) m_tbl[i] = 8'd0;
        end else if (m_act) begin
            m_t++;
            if (m_t == m_lat) begin
                m_tbl  = m_new;
                m_rank = m_prank;
            end
            if (m_t == m_lat + 1) m_act = 1'b0;
        end else if (start) begin
            model_insert(score);
            m_act = 1'b1;
            m_t   = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_act));
        chk("done", int'(done), int'(m_act && m_t == m_lat));
        if (!m_act) begin
            chk("hi1", int'(hi1), int'(m_tbl[0]));
            chk("hi2", int'(hi2), int'(m_tbl[1]));
            chk("hi3", int'(hi3), int'(m_tbl[2]));
            chk("hi4", int'(hi4), int'(m_tbl[3]));
            chk("hi5", int'(hi5), int'(m_tbl[4]));
        end
        if (m_act && m_t == m_lat) chk("rank", int'(rank), m_rank);
    end

    task automatic chk_tbl(input string nm, input int a, input int b, input int c, input int d, input int e);
        chk({nm, "_hi1"}, int'(hi1), a);
        chk({nm, "_hi2"}, int'(hi2), b);
        chk({nm, "_hi3"}, int'(hi3), c);
        chk({nm, "_hi4"}, int'(hi4), d);
        chk({nm, "_hi5"}, int'(hi5), e);
    endtask

    task automatic insert(input logic [7:0] s, output int rk, output int lat);
        @(negedge clk);
        start = 1'b1;
        score = s;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL insert_timeout: got no done expected done within 40 cycles");
        end
        rk = int'(rank);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic load_base();
        int rk, lat;
        pulse_clear();
        insert(8'd141, rk, lat);
        insert(8'd33, rk, lat);
        insert(8'd20, rk, lat);
        insert(8'd15, rk, lat);
        insert(8'd11, rk, lat);
        @(negedge clk);
    endtask

    task automatic quiet_window(input string nm, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({nm, "_done_pulses"}, pulses, 0);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int rk, lat;
        resetn = 1'b0;
        start  = 1'b0;
        clear  = 1'b0;
        score  = 8'd0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rank", int'(rank), 0);
        chk_tbl("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        insert(8'd20, rk, lat);
        chk("ins20_rank", rk, 1);
        chk("ins20_lat", lat, 7);
        insert(8'd141, rk, lat);
        chk("ins141_rank", rk, 1);
        insert(8'd33, rk, lat);
        chk("ins33_rank", rk, 2);
        @(negedge clk);
        chk_tbl("three", 141, 33, 20, 0, 0);
        insert(8'd15, rk, lat);
        chk("ins15_rank", rk, 4);
        insert(8'd11, rk, lat);
        chk("ins11_rank", rk, 5);
        chk("ins11_lat", lat, 7);

        insert(8'd25, rk, lat);
        chk("ins25_lat", lat, 7);
        chk("ins25_rank", rk, 3);
        @(negedge clk);
        chk_tbl("ins25", 141, 33, 25, 20, 15);

        load_base();
        insert(8'd11, rk, lat);
        chk("tie11_lat", lat, 5);
        chk("tie11_rank", rk, 0);
        insert(8'd5, rk, lat);
        chk("ins5_lat", lat, 5);
        chk("ins5_rank", rk, 0);
        @(negedge clk);
        chk_tbl("unplaced", 141, 33, 20, 15, 11);

        insert(8'd200, rk, lat);
        chk("ins200_rank", rk, 1);
        chk("ins200_lat", lat, 7);
        @(negedge clk);
        chk_tbl("ins200", 200, 141, 33, 20, 15);

        pulse_clear();
        insert(8'd0, rk, lat);
        chk("zero_rank", rk, 0);
        chk("zero_lat", lat, 5);

        // Clear lands mid-SHIFT; a start pulsed while busy must leave no trace.
        load_base();
        start = 1'b1;
        score = 8'd200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        score = 8'd99;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_busy", int'(busy), 0);
        chk("clr_done", int'(done), 0);
        chk_tbl("clr", 0, 0, 0, 0, 0);
        quiet_window("clr_after", 12);

        // Asynchronous reset while comparing.
        load_base();
        start = 1'b1;
        score = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_rank", int'(rank), 0);
        chk_tbl("arst", 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        start  = 1'b1;
        clear  = 1'b1;
        score  = 8'd77;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("sc_busy", int'(busy), 0);
        chk_tbl("sc", 0, 0, 0, 0, 0);
        quiet_window("sc_after", 10);

        // Randomised traffic: held starts, ties against live entries, rare clears and resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: score = m_tbl[$urandom_range(0, 4)];
                1: score = 8'($urandom_range(0, 255));
                2: score = 8'd0;
                default: score = 8'($urandom_range(250, 255));
            endcase
            clear = ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 699) == 0) begin
                #3;
                resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
